// File: rtl/pedagio_multipista.sv
// Multi-lane toll accumulator: per-lane edge capture and classification,
// round-robin charging into a saturating BCD revenue total.
module pedagio_multipista #(
  parameter int LANES       = 4,
  parameter int DIGITS      = 6,
  parameter int TARIFA1     = 10,
  parameter int TARIFA2     = 25,
  parameter int TARIFA3     = 50,
  parameter int PESO_MAX_C1 = 7,
  parameter int PESO_MAX_C2 = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LANES-1:0]    ready,
  input  logic [2*LANES-1:0]  eixos,
  input  logic [4*LANES-1:0]  peso,
  input  logic                clear_total,
  output logic [2*LANES-1:0]  categoria,
  output logic [4*DIGITS-1:0] total_bcd,
  output logic [15:0]         veiculos,
  output logic [7:0]          erros,
  output logic [LANES-1:0]    pendente,
  output logic                overflow,
  output logic [LANES-1:0]    perdido
);

  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [7:0] T1B =
    8'(((TARIFA1 / 10) << 4) | (TARIFA1 % 10));
  localparam logic [7:0] T2B =
    8'(((TARIFA2 / 10) << 4) | (TARIFA2 % 10));
  localparam logic [7:0] T3B =
    8'(((TARIFA3 / 10) << 4) | (TARIFA3 % 10));

  logic [LANES-1:0]    ready_q;
  logic                armed;
  logic [LANES-1:0]    rise;
  logic [LANES-1:0]    cap;
  logic [LANES-1:0]    lost;
  logic [LANES-1:0]    gnt_oh;
  logic [2*LANES-1:0]  cls;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       gnt;
  logic [PW-1:0]       ptr_nx;
  logic                gnt_v;
  logic [1:0]          gcat;
  logic [7:0]          tar;
  logic [4*DIGITS-1:0] sum;
  logic                sum_co;
  logic [4:0]          dsum;
  int                  idx;

  // armed masks the first cycle after reset so a held-high ready is no edge
  assign rise = armed ? (ready & ~ready_q) : '0;
  assign cap  = rise & (~pendente | gnt_oh);
  assign lost = rise & pendente & ~gnt_oh;

  always_comb begin
    cls = '0;
    for (int i = 0; i < LANES; i++) begin
      if (eixos[2*i +: 2] == 2'd0 &&
          int'(peso[4*i +: 4]) <= PESO_MAX_C1)
        cls[2*i +: 2] = 2'd1;
      else if (eixos[2*i +: 2] == 2'd1 &&
               int'(peso[4*i +: 4]) <= PESO_MAX_C2)
        cls[2*i +: 2] = 2'd2;
      else if (eixos[2*i +: 2] >= 2'd2 &&
               int'(peso[4*i +: 4]) > PESO_MAX_C2)
        cls[2*i +: 2] = 2'd3;
      else
        cls[2*i +: 2] = 2'd0;
    end
  end

  always_comb begin
    gnt_v = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < LANES; k++) begin
      idx = (int'(ptr) + k) % LANES;
      if (!gnt_v && pendente[idx]) begin
        gnt_v = 1'b1;
        gnt   = PW'(idx);
      end
    end
    if (clear_total)
      gnt_v = 1'b0;
  end

  assign gnt_oh = gnt_v ? (LANES'(1) << gnt) : '0;
  assign ptr_nx = (int'(gnt) == LANES - 1) ? '0 : gnt + PW'(1);
  assign gcat   = categoria[2*gnt +: 2];

  always_comb begin
    unique case (gcat)
      2'd1:    tar = T1B;
      2'd2:    tar = T2B;
      2'd3:    tar = T3B;
      default: tar = 8'h00;
    endcase
  end

  always_comb begin
    sum    = '0;
    sum_co = 1'b0;
    dsum   = '0;
    for (int j = 0; j < DIGITS; j++) begin
      dsum = {1'b0, total_bcd[4*j +: 4]} + {4'b0, sum_co};
      if (j < 2)
        dsum = dsum + {1'b0, tar[4*j +: 4]};
      if (dsum > 5'd9) begin
        dsum   = dsum - 5'd10;
        sum_co = 1'b1;
      end else begin
        sum_co = 1'b0;
      end
      sum[4*j +: 4] = dsum[3:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q   <= '0;
      armed     <= 1'b0;
      ptr       <= '0;
      pendente  <= '0;
      perdido   <= '0;
      categoria <= '0;
      total_bcd <= '0;
      veiculos  <= '0;
      erros     <= '0;
      overflow  <= 1'b0;
    end else begin
      ready_q  <= ready;
      armed    <= 1'b1;
      pendente <= (pendente & ~gnt_oh) | cap;
      perdido  <= (clear_total ? '0 : perdido) | lost;
      for (int i = 0; i < LANES; i++)
        if (cap[i])
          categoria[2*i +: 2] <= cls[2*i +: 2];
      if (gnt_v)
        ptr <= ptr_nx;
      if (clear_total) begin
        total_bcd <= '0;
        veiculos  <= '0;
        erros     <= '0;
        overflow  <= 1'b0;
      end else if (gnt_v) begin
        if (gcat != 2'd0) begin
          if (sum_co) begin
            total_bcd <= {DIGITS{4'h9}};
            overflow  <= 1'b1;
          end else begin
            total_bcd <= sum;
          end
          if (veiculos != 16'hFFFF)
            veiculos <= veiculos + 16'd1;
        end else if (erros != 8'hFF) begin
          erros <= erros + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pedagio_multipista.sv
// Directed bench for pedagio_multipista: capture, arbitration,
// BCD carry, lost events, saturation, clear and reset.
module tb_pedagio_multipista;

  logic        clk;
  logic        reset;
  logic [3:0]  ready;
  logic [7:0]  eixos;
  logic [15:0] peso;
  logic        clear_total;
  logic [7:0]  categoria;
  logic [23:0] total_bcd;
  logic [15:0] veiculos;
  logic [7:0]  erros;
  logic [3:0]  pendente;
  logic        overflow;
  logic [3:0]  perdido;

  logic [3:0]  ready2;
  logic [7:0]  eixos2;
  logic [15:0] peso2;
  logic        clear2;
  logic [7:0]  categoria2;
  logic [7:0]  total2;
  logic [15:0] veiculos2;
  logic [7:0]  erros2;
  logic [3:0]  pendente2;
  logic        overflow2;
  logic [3:0]  perdido2;

  int checks = 0;
  int errors = 0;

  pedagio_multipista dut (
    .clk(clk), .reset(reset), .ready(ready),
    .eixos(eixos), .peso(peso),
    .clear_total(clear_total), .categoria(categoria),
    .total_bcd(total_bcd), .veiculos(veiculos),
    .erros(erros), .pendente(pendente),
    .overflow(overflow), .perdido(perdido)
  );

  pedagio_multipista #(.DIGITS(2)) dut2 (
    .clk(clk), .reset(reset), .ready(ready2),
    .eixos(eixos2), .peso(peso2),
    .clear_total(clear2), .categoria(categoria2),
    .total_bcd(total2), .veiculos(veiculos2),
    .erros(erros2), .pendente(pendente2),
    .overflow(overflow2), .perdido(perdido2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l,
                          input logic [1:0] e,
                          input logic [3:0] p);
    eixos[2*l +: 2] = e;
    peso[4*l +: 4]  = p;
  endtask

  task automatic charge(input int l,
                        input logic [1:0] e,
                        input logic [3:0] p);
    set_lane(l, e, p);
    ready[l] = 1'b1;
    tick();
    ready[l] = 1'b0;
    tick();
  endtask

  task automatic charge2(input logic [1:0] e,
                         input logic [3:0] p);
    eixos2[1:0] = e;
    peso2[3:0]  = p;
    ready2[0] = 1'b1;
    tick();
    ready2[0] = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    ready = '0; eixos = '0; peso = '0; clear_total = 1'b0;
    ready2 = '0; eixos2 = '0; peso2 = '0; clear2 = 1'b0;
    tick(); tick();
    check("rst_total", 32'(total_bcd), 32'h0);
    check("rst_pend", 32'(pendente), 32'h0);
    check("rst_cat", 32'(categoria), 32'h0);
    check("rst_veic", 32'(veiculos), 32'h0);
    reset = 1'b1;
    tick();

    // T1 single lane
    set_lane(0, 2'd0, 4'd5);
    ready[0] = 1'b1;
    tick();
    check("t1_cat", 32'(categoria), 32'h01);
    check("t1_pend", 32'(pendente), 32'h1);
    check("t1_total_early", 32'(total_bcd), 32'h0);
    ready[0] = 1'b0;
    tick();
    check("t1_total", 32'(total_bcd), 32'h10);
    check("t1_veic", 32'(veiculos), 32'd1);
    check("t1_pend_clr", 32'(pendente), 32'h0);

    // T2 BCD carry
    charge(0, 2'd1, 4'd10);
    check("t2_35", 32'(total_bcd), 32'h35);
    charge(0, 2'd1, 4'd10);
    charge(0, 2'd1, 4'd10);
    check("t2_85", 32'(total_bcd), 32'h85);
    charge(0, 2'd0, 4'd7);
    check("t2_95", 32'(total_bcd), 32'h95);
    charge(3, 2'd1, 4'd12);
    check("t2_120", 32'(total_bcd), 32'h120);
    for (int d = 0; d < 6; d++)
      check("t2_digit", 32'(total_bcd[4*d +: 4] <= 4'd9), 32'd1);
    check("t2_cat", 32'(categoria), 32'h81);
    check("t2_veic", 32'(veiculos), 32'd6);

    // T3 contention
    set_lane(0, 2'd0, 4'd3);
    set_lane(1, 2'd1, 4'd12);
    set_lane(2, 2'd2, 4'd13);
    set_lane(3, 2'd3, 4'd5);
    ready = 4'hF;
    tick();
    check("t3_cat", 32'(categoria), 32'h39);
    check("t3_pend", 32'(pendente), 32'hF);
    ready = 4'h0;
    tick();
    check("t3_g0", 32'(total_bcd), 32'h130);
    check("t3_p0", 32'(pendente), 32'hE);
    tick();
    check("t3_g1", 32'(total_bcd), 32'h155);
    tick();
    check("t3_g2", 32'(total_bcd), 32'h205);
    check("t3_p2", 32'(pendente), 32'h8);
    tick();
    check("t3_g3", 32'(total_bcd), 32'h205);
    check("t3_erros", 32'(erros), 32'd1);
    check("t3_pend_end", 32'(pendente), 32'h0);
    check("t3_veic", 32'(veiculos), 32'd9);

    // T4 lost event
    charge(1, 2'd0, 4'd2);
    check("t4_pre", 32'(total_bcd), 32'h215);
    set_lane(1, 2'd0, 4'd2);
    set_lane(2, 2'd0, 4'd2);
    set_lane(3, 2'd0, 4'd2);
    ready = 4'hE;
    tick();
    check("t4_pend", 32'(pendente), 32'hE);
    ready = 4'h0;
    tick();
    check("t4_g2", 32'(total_bcd), 32'h225);
    set_lane(1, 2'd2, 4'd15);
    ready[1] = 1'b1;
    tick();
    check("t4_g3", 32'(total_bcd), 32'h235);
    check("t4_perdido", 32'(perdido), 32'h2);
    check("t4_pend1", 32'(pendente), 32'h2);
    check("t4_cat_keep", 32'(categoria), 32'h55);
    ready[1] = 1'b0;
    tick();
    check("t4_g1", 32'(total_bcd), 32'h245);
    check("t4_pend0", 32'(pendente), 32'h0);
    tick();
    check("t4_once", 32'(total_bcd), 32'h245);
    check("t4_veic", 32'(veiculos), 32'd13);

    // T5 saturation on the two-digit instance
    charge2(2'd2, 4'd13);
    check("t5_50", 32'(total2), 32'h50);
    check("t5_ov0", 32'(overflow2), 32'd0);
    charge2(2'd2, 4'd13);
    check("t5_99", 32'(total2), 32'h99);
    check("t5_ov1", 32'(overflow2), 32'd1);
    charge2(2'd0, 4'd0);
    check("t5_stay", 32'(total2), 32'h99);
    check("t5_veic", 32'(veiculos2), 32'd3);

    // T6 clear with lane2 pending
    set_lane(2, 2'd1, 4'd4);
    ready[2] = 1'b1;
    tick();
    check("t6_pend", 32'(pendente), 32'h4);
    ready[2] = 1'b0;
    clear_total = 1'b1;
    tick();
    clear_total = 1'b0;
    check("t6_clr_total", 32'(total_bcd), 32'h0);
    check("t6_clr_veic", 32'(veiculos), 32'd0);
    check("t6_clr_erros", 32'(erros), 32'd0);
    check("t6_clr_perd", 32'(perdido), 32'h0);
    check("t6_keep_pend", 32'(pendente), 32'h4);
    tick();
    check("t6_g2", 32'(total_bcd), 32'h25);
    check("t6_veic", 32'(veiculos), 32'd1);
    check("t6_pend0", 32'(pendente), 32'h0);

    // reset mid-burst, ready held high throughout
    for (int l = 0; l < 4; l++)
      set_lane(l, 2'd0, 4'd1);
    ready = 4'hF;
    tick();
    check("t6_burst", 32'(pendente), 32'hF);
    tick();
    check("t6_burst_g", 32'(total_bcd), 32'h35);
    #3 reset = 1'b0;
    #1;
    check("t6_rst_total", 32'(total_bcd), 32'h0);
    check("t6_rst_pend", 32'(pendente), 32'h0);
    check("t6_rst_cat", 32'(categoria), 32'h0);
    check("t6_rst_veic", 32'(veiculos), 32'h0);
    check("t6_rst_t2", 32'(total2), 32'h0);
    check("t6_rst_ov2", 32'(overflow2), 32'h0);
    #2 reset = 1'b1;
    tick(); tick(); tick();
    check("t6_post_pend", 32'(pendente), 32'h0);
    check("t6_post_total", 32'(total_bcd), 32'h0);
    check("t6_post_veic", 32'(veiculos), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
